// File: rtl/pipe_ctrl_seq.sv
// LEGv8 pipeline control sequencer: per-stage instruction/valid registers with stall,
// branch flush, load-use bubble insertion, per-stage class decode and committed NZCV flags.
module pipe_ctrl_seq #(
  parameter int INST_W      = 32,
  parameter int NUM_STAGES  = 4,
  parameter int ALU_STAGE   = 1,
  parameter int FLUSH_STAGE = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INST_W-1:0]            fetchInst,
  input  logic                         fetchValid,
  output logic                         fetchReady,
  input  logic                         stallReq,
  input  logic                         flushReq,
  input  logic [3:0]                   flagsIn,
  output logic [NUM_STAGES*INST_W-1:0] stageInst,
  output logic [NUM_STAGES-1:0]        stageValid,
  output logic [NUM_STAGES-1:0]        isLoad,
  output logic [NUM_STAGES-1:0]        isStore,
  output logic [NUM_STAGES-1:0]        isBranch,
  output logic [NUM_STAGES-1:0]        regWrite,
  output logic                         loadUseStall,
  output logic [3:0]                   flagsOut
);

  // The load whose result is not yet forwardable sits one stage ahead of decode.
  localparam int       HAZ_STAGE  = 1;
  localparam logic [4:0] XZR      = 5'd31;
  localparam bit       ALU_SQUASH = (ALU_STAGE < FLUSH_STAGE);

  logic [NUM_STAGES-1:0] addi_v, adds_v, subs_v, ldur_v, stur_v;
  logic [NUM_STAGES-1:0] b_v, bl_v, bcond_v, cbz_v, br_v;
  logic                  hazard;
  logic [3:0]            flags_reg, flags_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      logic [INST_W-1:0] inst_reg, inst_next, prev_inst;
      logic              valid_reg, valid_next, prev_valid;
      logic [10:0]       op;

      if (gi == 0) begin : g_src
        assign prev_inst  = fetchInst;
        assign prev_valid = fetchValid;
      end else begin : g_src
        assign prev_inst  = stageInst[(gi-1)*INST_W +: INST_W];
        assign prev_valid = stageValid[gi-1];
      end

      // Flush kills everything up to and including the resolving stage's successor slot.
      always_comb begin
        inst_next  = inst_reg;
        valid_next = valid_reg;
        if (!stallReq) begin
          if (flushReq && gi <= FLUSH_STAGE) begin
            inst_next  = '0;
            valid_next = 1'b0;
          end else if (hazard && gi == 0) begin
            inst_next  = inst_reg;
            valid_next = valid_reg;
          end else if (hazard && gi == HAZ_STAGE) begin
            inst_next  = '0;
            valid_next = 1'b0;
          end else begin
            inst_next  = prev_inst;
            valid_next = prev_valid;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!rst) begin
          inst_reg  <= '0;
          valid_reg <= 1'b0;
        end else begin
          inst_reg  <= inst_next;
          valid_reg <= valid_next;
        end
      end

      assign stageInst[gi*INST_W +: INST_W] = inst_reg;
      assign stageValid[gi]                 = valid_reg;

      assign op          = inst_reg[INST_W-1 -: 11];
      assign addi_v[gi]  = (op[10:1] == 10'b1001000100);
      assign adds_v[gi]  = (op == 11'b10101011000);
      assign subs_v[gi]  = (op == 11'b11101011000);
      assign ldur_v[gi]  = (op == 11'b11111000010);
      assign stur_v[gi]  = (op == 11'b11111000000);
      assign b_v[gi]     = (op[10:5] == 6'b000101);
      assign bl_v[gi]    = (op[10:5] == 6'b100101);
      assign bcond_v[gi] = (op[10:3] == 8'b01010100);
      assign cbz_v[gi]   = (op[10:3] == 8'b10110100);
      assign br_v[gi]    = (op == 11'b11010110000);

      assign isLoad[gi]   = valid_reg & ldur_v[gi];
      assign isStore[gi]  = valid_reg & stur_v[gi];
      assign isBranch[gi] = valid_reg & (b_v[gi] | bl_v[gi] | bcond_v[gi] | cbz_v[gi] | br_v[gi]);
      assign regWrite[gi] = valid_reg & (addi_v[gi] | adds_v[gi] | subs_v[gi] | ldur_v[gi] | bl_v[gi]);
    end
  endgenerate

  logic [4:0] ld_rd, rn0, rm0, rt0;
  logic       use_rn, use_rm, use_rt, src_match;

  assign ld_rd  = stageInst[HAZ_STAGE*INST_W +: 5];
  assign rn0    = stageInst[9:5];
  assign rm0    = stageInst[20:16];
  assign rt0    = stageInst[4:0];
  assign use_rn = addi_v[0] | adds_v[0] | subs_v[0] | ldur_v[0] | stur_v[0] | br_v[0];
  assign use_rm = adds_v[0] | subs_v[0];
  assign use_rt = stur_v[0] | cbz_v[0];

  assign src_match = (use_rn && rn0 == ld_rd) || (use_rm && rm0 == ld_rd) ||
                     (use_rt && rt0 == ld_rd);

  assign hazard = rst & ~flushReq & stageValid[0] & stageValid[HAZ_STAGE] &
                  ldur_v[HAZ_STAGE] & (ld_rd != XZR) & src_match;

  assign loadUseStall = hazard;
  assign fetchReady   = rst & ~stallReq & ~hazard;

  always_comb begin
    flags_next = flags_reg;
    if (!stallReq && stageValid[ALU_STAGE] && (adds_v[ALU_STAGE] | subs_v[ALU_STAGE]) &&
        !(ALU_SQUASH && flushReq))
      flags_next = flagsIn;
  end

  always_ff @(posedge clk) begin
    if (!rst) flags_reg <= 4'b0000;
    else      flags_reg <= flags_next;
  end

  assign flagsOut = flags_reg;

endmodule
